// File: rtl/frfb_mem_arbiter.sv
// Framebuffer memory bus sequencer/arbiter: one single-word access per grant, LCD in/out address counters.
// Optional host access port enabled by defining FRFB_ARB_HOST_EN.
module frfb_mem_arbiter #(
  parameter int AW          = 15,
  parameter int FRAME_WORDS = 32768,
  parameter int STARVE_MAX  = 8,
  parameter int TIMEOUT     = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sys_init_done,
  input  logic          in_req,
  input  logic          lcd_in_svsync,
  output logic          in_done,
  input  logic          out_req,
  input  logic          lcd_out_svsync,
  output logic          out_done,
`ifdef FRFB_ARB_HOST_EN
  input  logic          host_req,
  input  logic          host_wr,
  input  logic [AW-1:0] host_addr,
  output logic          host_done,
`endif
  input  logic          sys_ack,
  output logic [AW-1:0] sys_addr,
  output logic          sys_adsn,
  output logic          sys_r_wn,
  output logic          busy,
  output logic          timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} state_t;
  typedef enum logic [1:0] {OWN_OUT, OWN_IN, OWN_HOST} owner_t;

  localparam logic [AW-1:0] LAST_WORD = AW'(FRAME_WORDS - 1);
  localparam logic [3:0]    STARVE    = 4'(STARVE_MAX);
  localparam logic [7:0]    TMO_LAST  = 8'(TIMEOUT - 1);

  state_t        state, state_nxt;
  owner_t        owner, win;
  logic [3:0]    wc_out, wc_in, wc_host;
  logic [AW-1:0] in_cnt, out_cnt;
  logic [7:0]    tcnt;
  logic          grant, fin, abort;
  logic          st_out, st_in, st_host;
  logic          hreq, hwr;
  logic [AW-1:0] haddr;

`ifdef FRFB_ARB_HOST_EN
  assign hreq  = host_req;
  assign hwr   = host_wr;
  assign haddr = host_addr;
`else
  assign hreq  = 1'b0;
  assign hwr   = 1'b0;
  assign haddr = '0;
`endif

  function automatic logic [3:0] wc_next(input logic [3:0] c, input logic req,
                                         input logic dec, input logic won);
    if (!req || (dec && won)) return 4'd0;
    if (dec && c != 4'hF)     return c + 4'd1;
    return c;
  endfunction

  // Starving requesters outrank everyone else; fixed priority out > in > host breaks ties.
  always_comb begin
    st_out  = out_req && (wc_out >= STARVE);
    st_in   = in_req  && (wc_in  >= STARVE);
    st_host = hreq    && (wc_host >= STARVE);
    if (st_out)       win = OWN_OUT;
    else if (st_in)   win = OWN_IN;
    else if (st_host) win = OWN_HOST;
    else if (out_req) win = OWN_OUT;
    else if (in_req)  win = OWN_IN;
    else              win = OWN_HOST;

    state_nxt = state;
    grant     = 1'b0;
    fin       = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (sys_init_done && (out_req || in_req || hreq)) begin
          grant     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT_HI;
      WAIT_HI: begin
        if (tcnt >= TMO_LAST) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (sys_ack) begin
          state_nxt = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!sys_ack) begin
          fin       = 1'b1;
          state_nxt = IDLE;
        end else if (tcnt >= TMO_LAST) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= OWN_OUT;
      tcnt        <= '0;
      wc_out      <= '0;
      wc_in       <= '0;
      wc_host     <= '0;
      in_cnt      <= '0;
      out_cnt     <= '0;
      sys_addr    <= '0;
      sys_adsn    <= 1'b1;
      sys_r_wn    <= 1'b1;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      in_done     <= 1'b0;
      out_done    <= 1'b0;
`ifdef FRFB_ARB_HOST_EN
      host_done   <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      busy        <= (state_nxt != IDLE);
      sys_adsn    <= ~grant;
      timeout_err <= abort;
      in_done     <= fin && (owner == OWN_IN);
      out_done    <= fin && (owner == OWN_OUT);
`ifdef FRFB_ARB_HOST_EN
      host_done   <= fin && (owner == OWN_HOST);
`endif
      tcnt <= (state == WAIT_HI || state == WAIT_LO) ? tcnt + 8'd1 : 8'd0;

      if (grant) begin
        owner <= win;
        case (win)
          OWN_OUT: begin sys_addr <= out_cnt; sys_r_wn <= 1'b1; end
          OWN_IN:  begin sys_addr <= in_cnt;  sys_r_wn <= 1'b0; end
          default: begin sys_addr <= haddr;   sys_r_wn <= ~hwr; end
        endcase
      end else if (state_nxt == IDLE) begin
        sys_r_wn <= 1'b1;
      end

      wc_out  <= wc_next(wc_out,  out_req, grant, win == OWN_OUT);
      wc_in   <= wc_next(wc_in,   in_req,  grant, win == OWN_IN);
      wc_host <= wc_next(wc_host, hreq,    grant, win == OWN_HOST);

      // A vsync clear overrides the post-access increment of the same counter.
      if (!lcd_in_svsync)
        in_cnt <= '0;
      else if (fin && owner == OWN_IN)
        in_cnt <= (in_cnt == LAST_WORD) ? '0 : in_cnt + AW'(1);
      if (!lcd_out_svsync)
        out_cnt <= '0;
      else if (fin && owner == OWN_OUT)
        out_cnt <= (out_cnt == LAST_WORD) ? '0 : out_cnt + AW'(1);
    end
  end

endmodule

// File: tb/tb_frfb_mem_arbiter.sv
// Randomized scoreboard bench for frfb_mem_arbiter; host port exercised when FRFB_ARB_HOST_EN is defined.
module tb_frfb_mem_arbiter;

  localparam int AW          = 15;
  localparam int FRAME_WORDS = 6;
  localparam int STARVE_MAX  = 8;
  localparam int TIMEOUT     = 16;
`ifdef FRFB_ARB_HOST_EN
  localparam bit HOST = 1'b1;
`else
  localparam bit HOST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sys_init_done = 1'b0;
  logic          in_req = 1'b0, out_req = 1'b0;
  logic          lcd_in_svsync = 1'b1, lcd_out_svsync = 1'b1;
  logic          sys_ack = 1'b0;
  logic          host_req = 1'b0, host_wr = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic          in_done, out_done, host_done_w;
  logic [AW-1:0] sys_addr;
  logic          sys_adsn, sys_r_wn, busy, timeout_err;

  frfb_mem_arbiter #(
    .AW(AW), .FRAME_WORDS(FRAME_WORDS), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sys_init_done(sys_init_done),
    .in_req(in_req),
    .lcd_in_svsync(lcd_in_svsync),
    .in_done(in_done),
    .out_req(out_req),
    .lcd_out_svsync(lcd_out_svsync),
    .out_done(out_done),
`ifdef FRFB_ARB_HOST_EN
    .host_req(host_req),
    .host_wr(host_wr),
    .host_addr(host_addr),
    .host_done(host_done_w),
`endif
    .sys_ack(sys_ack),
    .sys_addr(sys_addr),
    .sys_adsn(sys_adsn),
    .sys_r_wn(sys_r_wn),
    .busy(busy),
    .timeout_err(timeout_err)
  );

`ifndef FRFB_ARB_HOST_EN
  assign host_done_w = 1'b0;
`endif

  always #5 clk = ~clk;

  // Reference model state: requester index 0 = out, 1 = in, 2 = host (also the fixed priority order).
  int            m_phase = 0;
  int            m_wait = 0, m_owner = 0, rise_at = 1, fall_at = 2;
  bit            m_seen_hi = 0, m_valid = 0, m_host_fin = 0, fast_ack = 0;
  int            m_wc[3];
  logic [AW-1:0] m_cnt_in = '0, m_cnt_out = '0;
  logic [AW:0]   gq[$];
  logic [2:0]    dq[$];
  bit            eq[$];
  int            n_checks = 0, n_fail = 0;
  int            init_low = 0, vin_low = 0, vout_low = 0;

  always @(posedge clk) begin
    bit req[3];
    int win;
    bit dec;
    req[0] = out_req;
    req[1] = in_req;
    req[2] = host_req;
    win = -1;
    dec = 1'b0;
    if (rst) begin
      m_valid = 1'b1;
      m_phase = 0;
      m_wait = 0;
      m_seen_hi = 1'b0;
      for (int i = 0; i < 3; i++) m_wc[i] = 0;
      m_cnt_in = '0;
      m_cnt_out = '0;
    end else begin
      if (m_phase == 0) begin
        if (sys_init_done && (req[0] || req[1] || req[2])) begin
          dec = 1'b1;
          for (int i = 0; i < 3; i++) if (win < 0 && req[i] && m_wc[i] >= STARVE_MAX) win = i;
          for (int i = 0; i < 3; i++) if (win < 0 && req[i]) win = i;
          case (win)
            0:       gq.push_back({1'b1, m_cnt_out});
            1:       gq.push_back({1'b0, m_cnt_in});
            default: gq.push_back({~host_wr, host_addr});
          endcase
          m_owner = win;
          m_phase = 1;
          m_wait = 0;
          m_seen_hi = 1'b0;
          if (fast_ack) begin
            rise_at = 1; fall_at = 2;
          end else if ($urandom_range(0, 11) == 0) begin
            rise_at = ($urandom_range(0, 1) != 0) ? 1000 : int'($urandom_range(1, 3));
            fall_at = 1000;
          end else begin
            rise_at = $urandom_range(1, 4);
            fall_at = rise_at + int'($urandom_range(1, 4));
          end
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else begin
        // m_wait = number of wait cycles spent, including this one
        m_wait++;
        if (m_seen_hi && !sys_ack) begin
          m_phase = 0;
          case (m_owner)
            0: begin
              dq.push_back(3'b010);
              m_cnt_out = (int'(m_cnt_out) == FRAME_WORDS - 1) ? '0 : m_cnt_out + 1'b1;
            end
            1: begin
              dq.push_back(3'b001);
              m_cnt_in = (int'(m_cnt_in) == FRAME_WORDS - 1) ? '0 : m_cnt_in + 1'b1;
            end
            default: begin
              dq.push_back(3'b100);
              m_host_fin = 1'b1;
            end
          endcase
        end else if (m_wait >= TIMEOUT) begin
          eq.push_back(1'b1);
          m_phase = 0;
        end else if (sys_ack) begin
          m_seen_hi = 1'b1;
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (!req[i] || (dec && win == i)) m_wc[i] = 0;
        else if (dec && m_wc[i] < 15) m_wc[i]++;
      end
      if (!lcd_in_svsync)  m_cnt_in  = '0;
      if (!lcd_out_svsync) m_cnt_out = '0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle, whatever the model queued for this cycle must appear, and nothing else.
  always @(negedge clk) begin
    logic [AW:0] g;
    logic [2:0]  d;
    bit          e;
    if (m_valid) begin
      if (gq.size() != 0) begin
        g = gq.pop_front();
        checkOutput("grant", 32'({sys_adsn, sys_r_wn, sys_addr}), 32'({1'b0, g}));
      end else begin
        checkOutput("strobe_idle", 32'(sys_adsn), 32'd1);
      end
      d = 3'b000;
      if (dq.size() != 0) d = dq.pop_front();
      checkOutput("done", 32'({host_done_w, out_done, in_done}), 32'(d));
      e = 1'b0;
      if (eq.size() != 0) e = eq.pop_front();
      checkOutput("timeout_err", 32'(timeout_err), 32'(e));
      checkOutput("busy", 32'(busy), 32'(m_phase != 0));
      if (m_phase == 0) checkOutput("r_wn_idle", 32'(sys_r_wn), 32'd1);
    end
  end

  // mode 0: init low with in_req held; 1: both LCD requests held, fast ack; 2: random; 3: quiet drain
  task automatic applyStimulus(input int mode);
    @(posedge clk);
    #1;
    sys_ack = (m_phase == 2) && (m_wait + 1 >= rise_at) && (m_wait + 1 < fall_at);
    if (m_host_fin) begin
      host_req = 1'b0;
      m_host_fin = 1'b0;
    end
    fast_ack = (mode == 1);
    case (mode)
      0: begin sys_init_done = 1'b0; in_req = 1'b1; out_req = 1'b0; end
      1: begin sys_init_done = 1'b1; in_req = 1'b1; out_req = 1'b1; end
      2: begin
        if ($urandom_range(0, 7) == 0) in_req  = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) out_req = ($urandom_range(0, 3) != 0);
        if (init_low > 0) init_low--;
        else if ($urandom_range(0, 99) == 0) init_low = $urandom_range(1, 10);
        if (vin_low > 0) vin_low--;
        else if ($urandom_range(0, 39) == 0) vin_low = $urandom_range(1, 3);
        if (vout_low > 0) vout_low--;
        else if ($urandom_range(0, 39) == 0) vout_low = $urandom_range(1, 3);
        sys_init_done  = (init_low == 0);
        lcd_in_svsync  = (vin_low == 0);
        lcd_out_svsync = (vout_low == 0);
        if (HOST && !host_req && $urandom_range(0, 19) == 0) begin
          host_req  = 1'b1;
          host_wr   = 1'($urandom);
          host_addr = AW'($urandom);
        end
      end
      default: begin
        sys_init_done = 1'b1; in_req = 1'b0; out_req = 1'b0;
        lcd_in_svsync = 1'b1; lcd_out_svsync = 1'b1;
      end
    endcase
  endtask

  initial begin
    for (int c = 0; c < 3; c++) applyStimulus(0);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) applyStimulus(0);
    for (int c = 0; c < 80; c++) applyStimulus(1);
    for (int c = 0; c < 1500; c++) applyStimulus(2);
    rst = 1'b1;
    applyStimulus(2);
    applyStimulus(2);
    rst = 1'b0;
    for (int c = 0; c < 1500; c++) applyStimulus(2);
    for (int c = 0; c < 40; c++) applyStimulus(3);
    checkOutput("drain", 32'(gq.size() + dq.size() + eq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
